// File: rtl/dcache_assoc.sv
// rtl/dcache_assoc.sv - write-through, no-write-allocate data cache, 1- or 2-way with per-set LRU
module dcache_assoc #(
  parameter int WORD_W         = 16,
  parameter int ADDR_W         = 16,
  parameter int WORDS_PER_LINE = 4,
  parameter int NUM_SETS       = 4,
  parameter int NUM_WAYS       = 2,
  parameter int CNT_W          = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_read,
  input  logic              cpu_write,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [WORD_W-1:0] cpu_wdata,
  output logic [WORD_W-1:0] cpu_rdata,
  output logic              cpu_done,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [WORD_W-1:0] mem_wdata,
  input  logic [WORD_W-1:0] mem_rdata,
  input  logic              mem_rvalid,
  input  logic              mem_wack,
  output logic [CNT_W-1:0]  hit_count,
  output logic [CNT_W-1:0]  miss_count
);

  localparam int OFF_W = $clog2(WORDS_PER_LINE);
  localparam int IDX_W = $clog2(NUM_SETS);
  localparam int TAG_W = ADDR_W - OFF_W - IDX_W;

  typedef enum logic [1:0] {S_IDLE, S_FILL, S_WRITE, S_RESP} state_t;

  state_t              state_q;
  logic                valid_q [NUM_WAYS][NUM_SETS];
  logic [TAG_W-1:0]    tag_q   [NUM_WAYS][NUM_SETS];
  logic [WORD_W-1:0]   data_q  [NUM_WAYS][NUM_SETS][WORDS_PER_LINE];
  logic [NUM_SETS-1:0] lru_q;
  logic [ADDR_W-1:0]   req_addr_q;
  logic [WORD_W-1:0]   req_wdata_q;
  logic                vic_q;
  logic [OFF_W-1:0]    cnt_q;

  // In IDLE the live CPU address is looked up; afterwards the captured one is.
  logic [ADDR_W-1:0] look_addr;
  logic [OFF_W-1:0]  look_off;
  logic [IDX_W-1:0]  look_idx;
  logic [TAG_W-1:0]  look_tag;

  assign look_addr = (state_q == S_IDLE) ? cpu_addr : req_addr_q;
  assign look_off  = look_addr[OFF_W-1:0];
  assign look_idx  = look_addr[OFF_W +: IDX_W];
  assign look_tag  = look_addr[ADDR_W-1 -: TAG_W];

  logic hit_any;
  logic hit_way;
  logic victim;

  // Tag compare across the ways of the addressed set.
  always_comb begin
    hit_any = 1'b0;
    hit_way = 1'b0;
    for (int w = 0; w < NUM_WAYS; w++) begin
      if (!hit_any && valid_q[w][look_idx] && (tag_q[w][look_idx] == look_tag)) begin
        hit_any = 1'b1;
        hit_way = 1'(w);
      end
    end
  end

  // Victim selection: lowest invalid way wins, otherwise the LRU way.
  always_comb begin
    victim = (NUM_WAYS == 2) ? lru_q[look_idx] : 1'b0;
    for (int w = NUM_WAYS - 1; w >= 0; w--) begin
      if (!valid_q[w][look_idx]) victim = 1'(w);
    end
  end

  logic              dw_en;
  logic              dw_way;
  logic [OFF_W-1:0]  dw_off;
  logic [WORD_W-1:0] dw_data;

  // Single data-array write port shared by line fills and write hits.
  always_comb begin
    dw_en   = 1'b0;
    dw_way  = vic_q;
    dw_off  = cnt_q;
    dw_data = mem_rdata;
    if (state_q == S_FILL && mem_rvalid) begin
      dw_en = 1'b1;
    end else if (state_q == S_WRITE && mem_wack && hit_any) begin
      dw_en   = 1'b1;
      dw_way  = hit_way;
      dw_off  = look_off;
      dw_data = req_wdata_q;
    end
  end

  // Line data has no reset: validity is carried entirely by valid_q.
  always_ff @(posedge clk) begin
    if (dw_en) data_q[dw_way][look_idx][dw_off] <= dw_data;
  end

  // Controller FSM with registered CPU/memory outputs, tags, valid, LRU and counters.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      cpu_done    <= 1'b0;
      cpu_rdata   <= '0;
      mem_req     <= 1'b0;
      mem_we      <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      hit_count   <= '0;
      miss_count  <= '0;
      lru_q       <= '0;
      req_addr_q  <= '0;
      req_wdata_q <= '0;
      vic_q       <= 1'b0;
      cnt_q       <= '0;
      for (int w = 0; w < NUM_WAYS; w++) begin
        for (int s = 0; s < NUM_SETS; s++) begin
          valid_q[w][s] <= 1'b0;
          tag_q[w][s]   <= '0;
        end
      end
    end else begin
      case (state_q)
        S_IDLE: begin
          if (cpu_write) begin
            req_addr_q  <= cpu_addr;
            req_wdata_q <= cpu_wdata;
            mem_req     <= 1'b1;
            mem_we      <= 1'b1;
            mem_addr    <= cpu_addr;
            mem_wdata   <= cpu_wdata;
            state_q     <= S_WRITE;
          end else if (cpu_read) begin
            req_addr_q <= cpu_addr;
            if (hit_any) begin
              cpu_rdata       <= data_q[hit_way][look_idx][look_off];
              lru_q[look_idx] <= ~hit_way;
              if (hit_count != {CNT_W{1'b1}}) hit_count <= hit_count + 1'b1;
              cpu_done        <= 1'b1;
              state_q         <= S_RESP;
            end else begin
              if (miss_count != {CNT_W{1'b1}}) miss_count <= miss_count + 1'b1;
              vic_q                     <= victim;
              valid_q[victim][look_idx] <= 1'b0;
              cnt_q                     <= '0;
              mem_req                   <= 1'b1;
              mem_we                    <= 1'b0;
              mem_addr                  <= {cpu_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
              state_q                   <= S_FILL;
            end
          end
        end
        S_FILL: begin
          if (mem_rvalid) begin
            if (cnt_q == look_off) cpu_rdata <= mem_rdata;
            if (&cnt_q) begin
              valid_q[vic_q][look_idx] <= 1'b1;
              tag_q[vic_q][look_idx]   <= look_tag;
              lru_q[look_idx]          <= ~vic_q;
              mem_req                  <= 1'b0;
              cpu_done                 <= 1'b1;
              state_q                  <= S_RESP;
            end else begin
              cnt_q    <= cnt_q + 1'b1;
              mem_addr <= {look_addr[ADDR_W-1:OFF_W], cnt_q + 1'b1};
            end
          end
        end
        S_WRITE: begin
          if (mem_wack) begin
            mem_req  <= 1'b0;
            mem_we   <= 1'b0;
            if (hit_any) lru_q[look_idx] <= ~hit_way;
            cpu_done <= 1'b1;
            state_q  <= S_RESP;
          end
        end
        default: begin
          cpu_done <= 1'b0;
          state_q  <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dcache_assoc.sv
// tb/tb_dcache_assoc.sv - directed table-driven bench for dcache_assoc
module tb_dcache_assoc;

  localparam int RD_LAT = 1;
  localparam int WR_LAT = 3;

  logic        clk = 1'b0;
  logic        reset;
  logic        cpu_read, cpu_write;
  logic [15:0] cpu_addr, cpu_wdata, cpu_rdata;
  logic        cpu_done;
  logic        mem_req, mem_we;
  logic [15:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_rvalid, mem_wack;
  logic [15:0] hit_count, miss_count;

  always #5 clk = ~clk;

  dcache_assoc dut (
    .clk        (clk),
    .reset      (reset),
    .cpu_read   (cpu_read),
    .cpu_write  (cpu_write),
    .cpu_addr   (cpu_addr),
    .cpu_wdata  (cpu_wdata),
    .cpu_rdata  (cpu_rdata),
    .cpu_done   (cpu_done),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .mem_rvalid (mem_rvalid),
    .mem_wack   (mem_wack),
    .hit_count  (hit_count),
    .miss_count (miss_count)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Backing memory: unwritten words read as 0x1000 + address.
  logic [15:0] mem_w [logic [15:0]];
  logic [15:0] rd_log [$];
  int          wr_n;
  logic [15:0] wr_addr_seen, wr_data_seen;

  function automatic logic [15:0] memval(input logic [15:0] a);
    return mem_w.exists(a) ? mem_w[a] : 16'h1000 + a;
  endfunction

  initial begin
    int wait_cnt;
    wait_cnt   = 0;
    mem_rvalid = 1'b0;
    mem_wack   = 1'b0;
    mem_rdata  = '0;
    forever begin
      @(negedge clk);
      mem_rvalid = 1'b0;
      mem_wack   = 1'b0;
      if (reset || !mem_req) begin
        wait_cnt = 0;
      end else begin
        wait_cnt++;
        if (wait_cnt >= (mem_we ? WR_LAT : RD_LAT)) begin
          wait_cnt = 0;
          if (mem_we) begin
            mem_wack         = 1'b1;
            wr_n++;
            wr_addr_seen     = mem_addr;
            wr_data_seen     = mem_wdata;
            mem_w[mem_addr]  = mem_wdata;
          end else begin
            mem_rvalid = 1'b1;
            mem_rdata  = memval(mem_addr);
            rd_log.push_back(mem_addr);
          end
        end
      end
    end
  end

  // One CPU transaction; lat counts posedges up to the one at which the CPU sees cpu_done.
  task automatic do_op(input bit is_wr, input logic [15:0] addr, input logic [15:0] wdata,
                       output logic [15:0] rdata, output int lat);
    bit timeout;
    timeout = 1'b1;
    lat     = 0;
    rdata   = '0;
    @(negedge clk);
    cpu_addr  = addr;
    cpu_wdata = wdata;
    cpu_read  = !is_wr;
    cpu_write = is_wr;
    for (int k = 1; k <= 200; k++) begin
      @(posedge clk);
      #1;
      if (cpu_done) begin
        lat     = k + 1;
        rdata   = cpu_rdata;
        timeout = 1'b0;
        break;
      end
    end
    cpu_read  = 1'b0;
    cpu_write = 1'b0;
    check("done_timeout", 32'(timeout), 32'd0);
    @(posedge clk);
    #1;
    check("done_one_cycle", 32'(cpu_done), 32'd0);
  endtask

  typedef struct {
    bit          is_wr;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [15:0] exp_rdata;
    int          exp_nrd;
    int          exp_nwr;
    int          exp_hits;
    int          exp_misses;
    int          exp_lat;
  } vec_t;

  task automatic run_vec(input vec_t v, input int idx);
    logic [15:0] rd;
    int          lat;
    string       tag;
    rd_log.delete();
    wr_n = 0;
    do_op(v.is_wr, v.addr, v.wdata, rd, lat);
    tag = $sformatf("v%0d", idx);
    if (!v.is_wr) check({tag, "_rdata"}, 32'(rd), 32'(v.exp_rdata));
    check({tag, "_nrd"}, 32'(rd_log.size()), 32'(v.exp_nrd));
    for (int i = 0; i < v.exp_nrd && i < rd_log.size(); i++)
      check($sformatf("%s_rdaddr%0d", tag, i), 32'(rd_log[i]), 32'((v.addr & 16'hFFFC) + 16'(i)));
    check({tag, "_nwr"}, 32'(wr_n), 32'(v.exp_nwr));
    if (v.exp_nwr > 0 && wr_n > 0) begin
      check({tag, "_wraddr"}, 32'(wr_addr_seen), 32'(v.addr));
      check({tag, "_wrdata"}, 32'(wr_data_seen), 32'(v.wdata));
    end
    check({tag, "_hits"}, 32'(hit_count), 32'(v.exp_hits));
    check({tag, "_misses"}, 32'(miss_count), 32'(v.exp_misses));
    if (v.exp_lat != 0) check({tag, "_lat"}, 32'(lat), 32'(v.exp_lat));
  endtask

  vec_t vecs [14];

  initial begin
    bit          got;
    int          base_n;
    logic [15:0] rd;
    int          lat;

    //           wr  addr      wdata     rdata     nrd nwr hit miss lat
    vecs[0]  = '{0, 16'h0013, 16'h0000, 16'h1013, 4, 0, 0, 1, 6};
    vecs[1]  = '{0, 16'h0011, 16'h0000, 16'h1011, 0, 0, 1, 1, 2};
    vecs[2]  = '{0, 16'h0050, 16'h0000, 16'h1050, 4, 0, 1, 2, 6};
    vecs[3]  = '{0, 16'h0011, 16'h0000, 16'h1011, 0, 0, 2, 2, 2};
    vecs[4]  = '{0, 16'h0090, 16'h0000, 16'h1090, 4, 0, 2, 3, 6};
    vecs[5]  = '{0, 16'h0011, 16'h0000, 16'h1011, 0, 0, 3, 3, 2};
    vecs[6]  = '{0, 16'h0050, 16'h0000, 16'h1050, 4, 0, 3, 4, 6};
    vecs[7]  = '{1, 16'h0012, 16'hBEEF, 16'h0000, 0, 1, 3, 4, 5};
    vecs[8]  = '{0, 16'h0012, 16'h0000, 16'hBEEF, 0, 0, 4, 4, 2};
    vecs[9]  = '{1, 16'h0A00, 16'h5A5A, 16'h0000, 0, 1, 4, 4, 5};
    vecs[10] = '{0, 16'h0A00, 16'h0000, 16'h5A5A, 4, 0, 4, 5, 6};
    vecs[11] = '{0, 16'h0A03, 16'h0000, 16'h1A03, 0, 0, 5, 5, 2};
    vecs[12] = '{0, 16'h0012, 16'h0000, 16'hBEEF, 0, 0, 6, 5, 2};
    vecs[13] = '{0, 16'h0024, 16'h0000, 16'h1024, 4, 0, 6, 6, 6};

    reset     = 1'b1;
    cpu_read  = 1'b0;
    cpu_write = 1'b0;
    cpu_addr  = '0;
    cpu_wdata = '0;
    wr_n      = 0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_done", 32'(cpu_done), 32'd0);
    check("rst_rdata", 32'(cpu_rdata), 32'd0);
    check("rst_mem_req", 32'(mem_req), 32'd0);
    check("rst_mem_we", 32'(mem_we), 32'd0);
    check("rst_mem_addr", 32'(mem_addr), 32'd0);
    check("rst_mem_wdata", 32'(mem_wdata), 32'd0);
    check("rst_hits", 32'(hit_count), 32'd0);
    check("rst_misses", 32'(miss_count), 32'd0);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 14; i++) run_vec(vecs[i], i);

    // Abandon a fill after two words have been accepted.
    rd_log.delete();
    @(negedge clk);
    cpu_addr = 16'h0070;
    cpu_read = 1'b1;
    got = 1'b0;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (rd_log.size() >= 2) begin
        got = 1'b1;
        break;
      end
    end
    check("midfill_reach2", 32'(got), 32'd1);
    @(posedge clk);
    #1;
    check("midfill_req_before", 32'(mem_req), 32'd1);
    reset    = 1'b1;
    cpu_read = 1'b0;
    #1;
    check("midfill_mem_req", 32'(mem_req), 32'd0);
    check("midfill_done", 32'(cpu_done), 32'd0);
    check("midfill_hits", 32'(hit_count), 32'd0);
    check("midfill_misses", 32'(miss_count), 32'd0);
    @(negedge clk);
    reset = 1'b0;

    run_vec('{0, 16'h0013, 16'h0000, 16'h1013, 4, 0, 0, 1, 6}, 100);
    run_vec('{0, 16'h0070, 16'h0000, 16'h1070, 4, 0, 0, 2, 6}, 101);
    do_op(1'b0, 16'h0072, 16'h0000, rd, lat);
    check("post_hit_rdata", 32'(rd), 32'h1072);
    check("post_hit_lat", 32'(lat), 32'd2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dcache_assoc.md
Name: dcache_assoc

Overview:
Parametrised write-through, write-no-allocate data cache between the datapath's second memory port and the backing memory. Direct-mapped (NUM_WAYS=1) or 2-way set-associative with per-set LRU (NUM_WAYS=2). Read misses perform a whole-line fill through a per-word memory handshake. Read hit and miss statistics counters are provided for performance measurement.

Parameters:
WORD_W, 16, data word width in bits; memory is word-addressed
ADDR_W, 16, word address width
WORDS_PER_LINE, 4, words per line; power of two, at least 2
NUM_SETS, 4, number of sets; power of two, at least 2
NUM_WAYS, 2, associativity; legal values are 1 and 2
CNT_W, 16, width of each statistics counter

Ports:
clk  in  1  clock; all state changes on posedge
reset  in  1  asynchronous, active-high reset
cpu_read  in  1  read request; held until cpu_done
cpu_write  in  1  write request; held until cpu_done
cpu_addr  in  ADDR_W  request word address
cpu_wdata  in  WORD_W  write data
cpu_rdata  out  WORD_W  read data; valid while cpu_done=1
cpu_done  out  1  one-cycle completion pulse
mem_req  out  1  memory request; held until mem_rvalid or mem_wack
mem_we  out  1  1 = write, 0 = read
mem_addr  out  ADDR_W  memory word address
mem_wdata  out  WORD_W  memory write data
mem_rdata  in  WORD_W  memory read data
mem_rvalid  in  1  read word valid; completes the current read
mem_wack  in  1  write accepted; completes the current write
hit_count  out  CNT_W  read hits, saturating
miss_count  out  CNT_W  read misses, saturating

Behaviour:
- Address split: offset = low log2(WORDS_PER_LINE) bits; index = next log2(NUM_SETS) bits; tag = remaining bits.
- Per line: valid bit, tag, WORDS_PER_LINE data words. Per set: one LRU bit (NUM_WAYS=2 only) naming the next victim way.
- Reset (asynchronous):
  - All valid bits and LRU bits cleared; state IDLE.
  - cpu_done=0, cpu_rdata=0, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0.
  - Both counters cleared.
  - An in-flight fill is abandoned. Partially filled lines stay invalid.
- FSM states: IDLE, FILL, WRITE, RESP.
- IDLE, at posedge:
  - cpu_write (has priority if both requests are high) -> WRITE. Drive mem_req=1, mem_we=1, mem_addr=cpu_addr, mem_wdata=cpu_wdata.
  - cpu_read with tag match in a valid way -> RESP. Register the word into cpu_rdata, increment hit_count, set LRU to the other way.
  - cpu_read with no match -> FILL. Increment miss_count.
    - Victim way: first invalid way (way 0 first), otherwise the LRU way.
    - Clear the victim's valid bit and zero the word counter.
    - Drive mem_req=1, mem_we=0, mem_addr = line base (offset bits zero).
- FILL:
  - On each mem_rvalid: write mem_rdata into victim word[counter]. If counter equals the requested offset, also load it into cpu_rdata.
  - If words remain, increment the counter and present the next address on the following cycle with mem_req kept high.
  - After the last word: set victim valid and tag, set LRU to the other way, drop mem_req, go to RESP.
- WRITE: on mem_wack, drop mem_req/mem_we. If a valid way matches the tag, update that word and set LRU to the other way. Go to RESP. A write miss does not allocate.
- RESP: cpu_done=1 for exactly one cycle, then IDLE. The CPU must change or drop its request in the RESP cycle; a request still held in IDLE is treated as new.
- Latency with a 1-cycle memory: read hit gives cpu_done on the 2nd posedge after the request is sampled. Writes and misses add memory time.
- mem_addr and mem_wdata stay stable while mem_req=1. mem_rvalid and mem_wack are ignored when no matching request is outstanding.
- Counters saturate at all-ones. Writes are not counted.
- Changes to cpu_addr or cpu_wdata outside IDLE are ignored; the request is captured when sampled.

Test Plan:
1. Reset; read 0x0013 (tag 0x001, idx 0, off 3); memory returns 0x1000+addr with 1-cycle latency -> 4 reads at 0x0010..0x0013; single cpu_done with cpu_rdata=0x1013; miss_count=1.
2. Then read 0x0011 -> no mem_req; cpu_done 2 cycles after the request; cpu_rdata=0x1011; hit_count=1.
3. LRU: read 0x0050 (fill way1), read 0x0011 (hit), read 0x0090 -> evicts tag 0x005. Then read 0x0050 misses and 0x0011 hits; final hit_count=3, miss_count=4.
4. Write 0x0012 with 0xBEEF, mem_wack after 3 cycles -> one mem write with addr 0x0012 and data 0xBEEF; following read of 0x0012 hits and returns 0xBEEF.
5. Write miss to 0x0A00 -> one mem write, no fill reads; next read of 0x0A00 misses and fills 0x0A00..0x0A03.
6. Assert reset after the 2nd mem_rvalid of a fill -> mem_req=0 and cpu_done=0 immediately; counters=0; re-read of 0x0013 misses and fills again.
